// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg
//   Shared definitions for the shift sequencer: FSM state encoding and the
//   bit-counter width helper.
//   No ports (package).
package shift_seq_ctrl_pkg;

  // Encodings are fixed to the legacy values so state dumps stay comparable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABRT  = 2'd3
  } state_e;

  // Bits needed for a counter that spans 0..width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
//   Parallel-word request channel between a requester and shift_seq_ctrl.
//   Signals:
//     req    requester has a word on data
//     data   WIDTH-bit parallel word, sampled on the accept edge only
//     abort  cancel the word currently being shifted
//     ready  controller can accept a word
//   Modports: master = requester side, slave = controller side.
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 2
);
  logic             req;
  logic [WIDTH-1:0] data;
  logic             abort;
  logic             ready;

  modport master (output req, output data, output abort, input ready);
  modport slave  (input req, input data, input abort, output ready);
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Loads one WIDTH-bit word per req/ready handshake into a serial DFF chain,
//   driving the chain D input MSB-first with shift_en high for exactly WIDTH
//   clocks, then pulsing done. An abort during shifting pulses aborted instead.
//   Ports:
//     C         clock, rising edge
//     nR        asynchronous active-low reset
//     bus       request channel (slave): req, data, abort in; ready out
//     D_out     serial bit to the chain D input (0 when not shifting)
//     shift_en  chain clock-enable
//     busy      word in flight (SHIFT or DONE)
//     done      1-cycle pulse, full word is in the chain
//     aborted   1-cycle pulse, word was cancelled
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             C,
  input  logic             nR,
  shift_seq_ctrl_if.slave  bus,
  output logic             D_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned      CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bit counter (load / increment / terminal count) is folded into the FSM.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          sh_d    = bus.data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        // abort takes priority over completing the last bit
        if (bus.abort) begin
          state_d = ST_ABRT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ABRT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign shift_en  = (state_q == ST_SHIFT);
  assign D_out     = shift_en & sh_q[WIDTH-1];
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = (state_q == ST_ABRT);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
//   Directed bench for shift_seq_ctrl (WIDTH=2). Stimulus pushes the expected
//   serial bits and the expected completion event (done with chain contents,
//   or aborted) into queues; a monitor on the falling edge pops and compares
//   whenever the DUT shifts or signals completion. Cycle-exact handshake
//   timing is checked directly in the stimulus.
module tb_shift_seq_ctrl;

  localparam int unsigned WIDTH = 2;

  logic C  = 1'b0;
  logic nR = 1'b0;
  logic D_out, shift_en, busy, done, aborted;

  always #5 C = ~C;

  shift_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .C        (C),
    .nR       (nR),
    .bus      (bus),
    .D_out    (D_out),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  // Model of the downstream DFF chain: chain[0] is Q1, chain[WIDTH-1] is Q<WIDTH>.
  logic [WIDTH-1:0] chain = '0;
  always @(posedge C) begin
    if (shift_en) chain <= WIDTH'({chain, D_out});
  end

  typedef struct packed {
    logic             is_done;
    logic [WIDTH-1:0] chain;
  } ev_t;

  logic bit_q[$];
  ev_t  ev_q[$];
  ev_t  mon_e;

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expect the top nbits of w on D_out, then a done (chain == w) or an abort.
  task automatic expect_word(input logic [WIDTH-1:0] w, input int unsigned nbits, input logic is_done);
    ev_t e;
    for (int unsigned i = 0; i < nbits; i++) bit_q.push_back(w[WIDTH-1-i]);
    e.is_done = is_done;
    e.chain   = w;
    ev_q.push_back(e);
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge C) begin
    if (shift_en) begin
      if (bit_q.size() == 0) check1("unexpected_shift_en", shift_en, 1'b0);
      else                   check1("d_out_bit", D_out, bit_q.pop_front());
    end else begin
      check1("d_out_zero_when_idle", D_out, 1'b0);
    end
    if (done || aborted) begin
      if (ev_q.size() == 0) begin
        check1("unexpected_done", done, 1'b0);
        check1("unexpected_aborted", aborted, 1'b0);
      end else begin
        mon_e = ev_q.pop_front();
        check1("event_done", done, mon_e.is_done);
        check1("event_aborted", aborted, ~mon_e.is_done);
        if (mon_e.is_done) checkw("chain_contents", chain, mon_e.chain);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.req   = 1'b0;
    bus.data  = '0;
    bus.abort = 1'b0;

    // Power-on reset values
    #1;
    check1("rst_ready", bus.ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_shift_en", shift_en, 1'b0);
    check1("rst_done", done, 1'b0);
    step();
    step();
    nR = 1'b1;
    step();

    // Single word 2'b10: D_out 1,0; done at k+3; ready at k+4
    bus.req  = 1'b1;
    bus.data = 2'b10;
    expect_word(2'b10, 2, 1'b1);
    step();                                  // edge k
    bus.req  = 1'b0;
    bus.data = 2'b11;                        // late data change must not matter
    check1("w1_shift_en_k1", shift_en, 1'b1);
    check1("w1_ready_k1", bus.ready, 1'b0);
    check1("w1_busy_k1", busy, 1'b1);
    step();
    check1("w1_shift_en_k2", shift_en, 1'b1);
    step();
    check1("w1_done_k3", done, 1'b1);
    check1("w1_shift_en_k3", shift_en, 1'b0);
    check1("w1_busy_k3", busy, 1'b1);
    check1("w1_ready_k3", bus.ready, 1'b0);
    step();
    check1("w1_ready_k4", bus.ready, 1'b1);
    check1("w1_done_k4", done, 1'b0);
    check1("w1_busy_k4", busy, 1'b0);

    // Back-to-back with req held: 2'b01 then 2'b11, second accept at k+4
    bus.req  = 1'b1;
    bus.data = 2'b01;
    expect_word(2'b01, 2, 1'b1);
    step();                                  // edge k
    bus.data = 2'b11;
    expect_word(2'b11, 2, 1'b1);
    step();
    step();
    check1("b2b_done_k3", done, 1'b1);
    step();
    check1("b2b_ready_k4", bus.ready, 1'b1);
    check1("b2b_shift_en_k4", shift_en, 1'b0);
    step();                                  // edge k+4: second accept
    check1("b2b_second_accept_shift_en", shift_en, 1'b1);
    check1("b2b_second_accept_ready", bus.ready, 1'b0);
    bus.req = 1'b0;
    step();
    step();
    check1("b2b_second_done", done, 1'b1);
    step();
    check1("b2b_ready_after", bus.ready, 1'b1);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    step();
    check1("idle_abort_ready", bus.ready, 1'b1);
    check1("idle_abort_aborted", aborted, 1'b0);
    bus.abort = 1'b0;

    // Abort on the first SHIFT cycle: aborted at k+2, ready at k+3
    bus.req  = 1'b1;
    bus.data = 2'b10;
    expect_word(2'b10, 1, 1'b0);
    step();                                  // edge k
    bus.req   = 1'b0;
    bus.abort = 1'b1;
    step();                                  // edge k+1
    check1("ab1_aborted_k2", aborted, 1'b1);
    check1("ab1_shift_en_k2", shift_en, 1'b0);
    check1("ab1_done_k2", done, 1'b0);
    check1("ab1_busy_k2", busy, 1'b0);
    check1("ab1_ready_k2", bus.ready, 1'b0);
    bus.abort = 1'b0;
    step();
    check1("ab1_ready_k3", bus.ready, 1'b1);
    check1("ab1_aborted_k3", aborted, 1'b0);

    // abort coincides with the last-bit edge: ABRT wins
    bus.req  = 1'b1;
    bus.data = 2'b11;
    expect_word(2'b11, 2, 1'b0);
    step();                                  // edge k
    bus.req = 1'b0;
    step();                                  // cycle k+2, last shift cycle
    bus.abort = 1'b1;
    step();                                  // edge k+2
    check1("ab_last_aborted", aborted, 1'b1);
    check1("ab_last_done", done, 1'b0);
    bus.abort = 1'b0;
    step();
    check1("ab_last_ready", bus.ready, 1'b1);
    check1("ab_last_done_after", done, 1'b0);

    // req while busy (cycle k+2) with data 2'b00 is ignored
    bus.req  = 1'b1;
    bus.data = 2'b01;
    expect_word(2'b01, 2, 1'b1);
    step();                                  // edge k
    bus.req = 1'b0;
    step();                                  // cycle k+2
    bus.req  = 1'b1;
    bus.data = 2'b00;
    step();                                  // cycle k+3
    check1("busy_req_done", done, 1'b1);
    bus.req = 1'b0;
    step();
    check1("busy_req_ready_k4", bus.ready, 1'b1);
    step();
    check1("busy_req_not_queued_ready", bus.ready, 1'b1);
    check1("busy_req_not_queued_shift", shift_en, 1'b0);

    // Reset asserted mid-SHIFT: immediate return to reset values
    bus.req  = 1'b1;
    bus.data = 2'b11;
    step();                                  // edge k
    bus.req = 1'b0;
    check1("mid_rst_shifting", shift_en, 1'b1);
    #1;
    nR = 1'b0;
    #1;
    check1("mid_rst_ready", bus.ready, 1'b1);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_shift_en", shift_en, 1'b0);
    check1("mid_rst_d_out", D_out, 1'b0);
    check1("mid_rst_done", done, 1'b0);
    check1("mid_rst_aborted", aborted, 1'b0);
    step();
    nR = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check1("post_rst_ready", bus.ready, 1'b1);

    check_int("pending_bits", bit_q.size(), 0);
    check_int("pending_events", ev_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
